hls_run_sequencer: RTL

Synthesizable successor to the per-kernel simulation harness. It drives the start/done handshake of an HLS-generated top (e.g. main) for a programmable number of back-to-back runs. It measures the cycle count of each run and enforces a per-run timeout. It accumulates total/min/max statistics so the same harness can run on the Artix-7 board as well as in simulation.

---
 rtl/hls_run_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/hls_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hls_run_sequencer
//  Purpose  : Drives the reset/start/done handshake of an HLS-generated top
//             for a programmable number of back-to-back runs. Measures each
//             run (start cycle through done cycle inclusive), enforces a
//             per-run timeout and accumulates total/min/max statistics.
//  Ports    : clock, reset        - clock, synchronous active-high reset
//             go, num_runs        - campaign start pulse and run count
//             dut_reset           - DUT reset, asserted level DUT_RST_POL
//             dut_start_port      - one-cycle start pulse to the DUT
//             dut_done_port       - done pulse from the DUT
//             busy                - campaign in progress
//             run_valid/run_*     - per-run result (index, cycles, timeout)
//             campaign_done/_ok   - end-of-campaign pulse and status
//             runs_done, total_cycles, min_cycles, max_cycles - statistics
//  Revision : 1.0 - initial release
// ============================================================================
module hls_run_sequencer #(
  parameter int              CNT_WIDTH   = 32,
  parameter int              RUNS_WIDTH  = 16,
  parameter longint unsigned TIMEOUT     = 200000000,
  parameter int              RST_CYCLES  = 2,
  parameter logic            DUT_RST_POL = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic [RUNS_WIDTH-1:0] num_runs,
  output logic                  dut_reset,
  output logic                  dut_start_port,
  input  logic                  dut_done_port,
  output logic                  busy,
  output logic                  run_valid,
  output logic [RUNS_WIDTH-1:0] run_index,
  output logic [CNT_WIDTH-1:0]  run_cycles,
  output logic                  run_timeout,
  output logic                  campaign_done,
  output logic                  campaign_ok,
  output logic [RUNS_WIDTH-1:0] runs_done,
  output logic [CNT_WIDTH-1:0]  total_cycles,
  output logic [CNT_WIDTH-1:0]  min_cycles,
  output logic [CNT_WIDTH-1:0]  max_cycles
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_RST    = 3'd1;
  localparam logic [2:0] c_START  = 3'd2;
  localparam logic [2:0] c_WAIT   = 3'd3;
  localparam logic [2:0] c_REPORT = 3'd4;
  localparam logic [2:0] c_FIN    = 3'd5;

  localparam int                 c_RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_RCW-1:0]   c_RST_LAST = c_RCW'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_TIMEOUT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] c_ONE     = CNT_WIDTH'(1);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [c_RCW-1:0]      r_rst_cnt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [RUNS_WIDTH-1:0] r_num_runs;
  logic [RUNS_WIDTH-1:0] r_runs_done;
  logic [RUNS_WIDTH-1:0] r_run_index;
  logic [CNT_WIDTH-1:0]  r_run_cycles;
  logic                  r_run_timeout;
  logic                  r_ok;
  logic [CNT_WIDTH-1:0]  r_total;
  logic [CNT_WIDTH-1:0]  r_min;
  logic [CNT_WIDTH-1:0]  r_max;

  logic                  w_in_run;
  logic                  w_capture;
  logic                  w_hit_timeout;
  logic [CNT_WIDTH:0]    w_sum;
  logic [CNT_WIDTH-1:0]  w_total_sat;

  // r_cnt already includes the current cycle (loaded with 1 for START).
  assign w_in_run      = (r_state == c_START) || (r_state == c_WAIT);
  assign w_hit_timeout = w_in_run && !dut_done_port && (r_cnt == c_TIMEOUT);
  assign w_capture     = w_in_run && (dut_done_port || (r_cnt == c_TIMEOUT));

  assign w_sum       = {1'b0, r_total} + {1'b0, r_cnt};
  assign w_total_sat = w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (go) begin
          w_next = (num_runs == '0) ? c_FIN : c_RST;
        end
      end
      c_RST: begin
        if (r_rst_cnt == c_RST_LAST) begin
          w_next = c_START;
        end
      end
      c_START, c_WAIT: begin
        if (w_capture) begin
          w_next = c_REPORT;
        end else begin
          w_next = c_WAIT;
        end
      end
      c_REPORT: begin
        // r_runs_done was already advanced when the run was captured.
        if (r_run_timeout || (r_runs_done >= r_num_runs)) begin
          w_next = c_FIN;
        end else begin
          w_next = c_RST;
        end
      end
      c_FIN:   w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    dut_reset      = DUT_RST_POL;
    dut_start_port = 1'b0;
    busy           = 1'b0;
    run_valid      = 1'b0;
    campaign_done  = 1'b0;
    case (r_state)
      c_RST:    busy = 1'b1;
      c_START: begin
        busy           = 1'b1;
        dut_reset      = ~DUT_RST_POL;
        dut_start_port = 1'b1;
      end
      c_WAIT: begin
        busy      = 1'b1;
        dut_reset = ~DUT_RST_POL;
      end
      c_REPORT: begin
        busy      = 1'b1;
        run_valid = 1'b1;
      end
      c_FIN:   campaign_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: counters, captured run result and statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rst_cnt     <= '0;
      r_cnt         <= '0;
      r_num_runs    <= '0;
      r_runs_done   <= '0;
      r_run_index   <= '0;
      r_run_cycles  <= '0;
      r_run_timeout <= 1'b0;
      r_ok          <= 1'b0;
      r_total       <= '0;
      r_min         <= '0;
      r_max         <= '0;
    end else begin
      r_rst_cnt <= (r_state == c_RST) ? r_rst_cnt + c_RCW'(1) : '0;

      if ((r_state == c_IDLE) && go) begin
        r_num_runs  <= num_runs;
        r_runs_done <= '0;
        r_total     <= '0;
        r_min       <= '0;
        r_max       <= '0;
        r_ok        <= 1'b1;
      end

      if (r_state == c_RST) begin
        r_cnt <= c_ONE;
      end else if (w_in_run && !w_capture) begin
        r_cnt <= r_cnt + c_ONE;
      end

      if (w_capture) begin
        r_run_index   <= r_runs_done;
        r_run_cycles  <= r_cnt;
        r_run_timeout <= w_hit_timeout;
        if (w_hit_timeout) begin
          r_ok <= 1'b0;
        end else begin
          r_runs_done <= r_runs_done + RUNS_WIDTH'(1);
          r_total     <= w_total_sat;
          if ((r_runs_done == '0) || (r_cnt < r_min)) begin
            r_min <= r_cnt;
          end
          if ((r_runs_done == '0) || (r_cnt > r_max)) begin
            r_max <= r_cnt;
          end
        end
      end
    end
  end

  assign run_index    = r_run_index;
  assign run_cycles   = r_run_cycles;
  assign run_timeout  = r_run_timeout;
  assign campaign_ok  = r_ok;
  assign runs_done    = r_runs_done;
  assign total_cycles = r_total;
  assign min_cycles   = r_min;
  assign max_cycles   = r_max;

endmodule
`default_nettype wire
